// File: rtl/mimo_rx_combiner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mimo_rx_combiner : N-channel 1-bit ADC beam combiner, double-buffered weights
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module mimo_rx_combiner #(
  parameter  int N_CH   = 4,
  parameter  int COEF_W = 6,
  parameter  int OUT_W  = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  input  logic [N_CH-1:0]          ADC_IN,
  input  logic [N_CH-1:0]          CH_MASK,
  input  logic                     MODE,
  input  logic [CH_W-1:0]          MON_CH,
  input  logic                     COEF_VALID,
  output logic                     COEF_READY,
  input  logic [CH_W-1:0]          COEF_CH,
  input  logic signed [COEF_W-1:0] COEF_COS,
  input  logic signed [COEF_W-1:0] COEF_SIN,
  input  logic                     COEF_COMMIT,
  output logic signed [OUT_W-1:0]  I_TOTAL,
  output logic signed [OUT_W-1:0]  Q_TOTAL,
  output logic                     OUT_VALID,
  output logic                     OVF
);

  localparam int TERM_W = COEF_W + 1;
  localparam int SUM_W  = COEF_W + 1 + CH_W;
  localparam int C_MAXI = (2 ** (OUT_W - 1)) - 1;
  localparam int C_MINI = -(2 ** (OUT_W - 1));
  localparam logic signed [COEF_W-1:0] C_COS_ONE = {1'b0, {(COEF_W-1){1'b1}}};

  logic signed [COEF_W-1:0] r_sh_cos  [N_CH];
  logic signed [COEF_W-1:0] r_sh_sin  [N_CH];
  logic signed [COEF_W-1:0] r_act_cos [N_CH];
  logic signed [COEF_W-1:0] r_act_sin [N_CH];
  logic signed [COEF_W-1:0] w_nxt_cos [N_CH];
  logic signed [COEF_W-1:0] w_nxt_sin [N_CH];
  logic                     r_coef_ready;
  logic                     w_wr_ok;

  logic [N_CH-1:0]          w_en;
  logic signed [TERM_W-1:0] w_ti [N_CH];
  logic signed [TERM_W-1:0] w_tq [N_CH];
  logic signed [TERM_W-1:0] r_s1_i [N_CH];
  logic signed [TERM_W-1:0] r_s1_q [N_CH];
  logic                     r_s1_v;

  logic signed [SUM_W-1:0]  w_sum_i, w_sum_q;
  logic signed [SUM_W-1:0]  r_s2_i, r_s2_q;
  logic                     r_s2_v;

  logic signed [OUT_W-1:0]  w_sat_i, w_sat_q;
  logic                     w_ovf;
  logic signed [OUT_W-1:0]  r_i, r_q;
  logic                     r_v, r_ovf;

  // Shadow bank after this edge's write; commit copies it so a same-edge write lands.
  always_comb begin
    w_wr_ok = COEF_VALID && r_coef_ready && (int'(COEF_CH) < N_CH);
    for (int k = 0; k < N_CH; k++) begin
      w_nxt_cos[k] = r_sh_cos[k];
      w_nxt_sin[k] = r_sh_sin[k];
      if (w_wr_ok && int'(COEF_CH) == k) begin
        w_nxt_cos[k] = COEF_COS;
        w_nxt_sin[k] = COEF_SIN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_coef_ready <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_sh_cos[k]  <= C_COS_ONE;
        r_sh_sin[k]  <= '0;
        r_act_cos[k] <= C_COS_ONE;
        r_act_sin[k] <= '0;
      end
    end else begin
      r_coef_ready <= !COEF_COMMIT;
      for (int k = 0; k < N_CH; k++) begin
        r_sh_cos[k] <= w_nxt_cos[k];
        r_sh_sin[k] <= w_nxt_sin[k];
        if (COEF_COMMIT) begin
          r_act_cos[k] <= w_nxt_cos[k];
          r_act_sin[k] <= w_nxt_sin[k];
        end
      end
    end
  end

  // Widen before negating so the most negative weight flips exactly.
  always_comb begin
    w_en = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_en[k] = MODE ? (int'(MON_CH) == k) : CH_MASK[k];
      w_ti[k] = '0;
      w_tq[k] = '0;
      if (w_en[k]) begin
        w_ti[k] = ADC_IN[k] ? TERM_W'(r_act_cos[k]) : -TERM_W'(r_act_cos[k]);
        w_tq[k] = ADC_IN[k] ? TERM_W'(r_act_sin[k]) : -TERM_W'(r_act_sin[k]);
      end
    end
  end

  always_comb begin
    w_sum_i = '0;
    w_sum_q = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_sum_i = w_sum_i + SUM_W'(r_s1_i[k]);
      w_sum_q = w_sum_q + SUM_W'(r_s1_q[k]);
    end
  end

  always_comb begin
    w_sat_i = (int'(r_s2_i) > C_MAXI) ? OUT_W'(C_MAXI) :
              (int'(r_s2_i) < C_MINI) ? OUT_W'(C_MINI) : OUT_W'(r_s2_i);
    w_sat_q = (int'(r_s2_q) > C_MAXI) ? OUT_W'(C_MAXI) :
              (int'(r_s2_q) < C_MINI) ? OUT_W'(C_MINI) : OUT_W'(r_s2_q);
    w_ovf   = (int'(r_s2_i) > C_MAXI) || (int'(r_s2_i) < C_MINI) ||
              (int'(r_s2_q) > C_MAXI) || (int'(r_s2_q) < C_MINI);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_v    <= 1'b0;
      r_s2_i <= '0;
      r_s2_q <= '0;
      r_i    <= '0;
      r_q    <= '0;
      r_ovf  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_s1_i[k] <= '0;
        r_s1_q[k] <= '0;
      end
    end else begin
      r_s1_v <= IN_VALID;
      if (IN_VALID) begin
        for (int k = 0; k < N_CH; k++) begin
          r_s1_i[k] <= w_ti[k];
          r_s1_q[k] <= w_tq[k];
        end
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_i <= w_sum_i;
        r_s2_q <= w_sum_q;
      end
      r_v <= r_s2_v;
      if (r_s2_v) begin
        r_i   <= w_sat_i;
        r_q   <= w_sat_q;
        r_ovf <= w_ovf;
      end
    end
  end

  assign COEF_READY = r_coef_ready;
  assign I_TOTAL    = r_i;
  assign Q_TOTAL    = r_q;
  assign OUT_VALID  = r_v;
  assign OVF        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mimo_rx_combiner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mimo_rx_combiner : scoreboard bench for the N-channel rx combiner
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mimo_rx_combiner;
  localparam int N_CH = 4;
  localparam int COEF_W = 6;
  localparam int OUT_W = 8;
  localparam int CH_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [N_CH-1:0] adc = '0;
  logic [N_CH-1:0] mask = '1;
  logic mode = 1'b0;
  logic [CH_W-1:0] mon_ch = '0;
  logic coef_valid = 1'b0;
  logic coef_ready;
  logic [CH_W-1:0] coef_ch = '0;
  logic signed [COEF_W-1:0] coef_cos = '0;
  logic signed [COEF_W-1:0] coef_sin = '0;
  logic coef_commit = 1'b0;
  logic signed [OUT_W-1:0] i_total, q_total;
  logic out_valid, ovf;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic signed [OUT_W-1:0] i;
    logic signed [OUT_W-1:0] q;
    logic ovf;
    int cyc;
  } exp_t;
  exp_t sb[$];

  int m_sh_cos[N_CH], m_sh_sin[N_CH], m_act_cos[N_CH], m_act_sin[N_CH];
  bit m_ready;
  logic signed [OUT_W-1:0] last_i = '0, last_q = '0;

  mimo_rx_combiner #(.N_CH(N_CH), .COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .ADC_IN(adc), .CH_MASK(mask),
    .MODE(mode), .MON_CH(mon_ch), .COEF_VALID(coef_valid), .COEF_READY(coef_ready),
    .COEF_CH(coef_ch), .COEF_COS(coef_cos), .COEF_SIN(coef_sin),
    .COEF_COMMIT(coef_commit), .I_TOTAL(i_total), .Q_TOTAL(q_total),
    .OUT_VALID(out_valid), .OVF(ovf)
  );

  always #5 clk = ~clk;

  function automatic int sat(int v);
    return (v > 127) ? 127 : (v < -128) ? -128 : v;
  endfunction

  function automatic exp_t predict(int c);
    exp_t e;
    int si = 0;
    int sq = 0;
    bit en;
    for (int k = 0; k < N_CH; k++) begin
      en = mode ? (int'(mon_ch) == k) : mask[k];
      if (en) begin
        si += adc[k] ? m_act_cos[k] : -m_act_cos[k];
        sq += adc[k] ? m_act_sin[k] : -m_act_sin[k];
      end
    end
    e.i = 8'(sat(si));
    e.q = 8'(sat(sq));
    e.ovf = (sat(si) != si) || (sat(sq) != sq);
    e.cyc = c;
    return e;
  endfunction

  // Reference model: expected results pushed as samples are captured.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b0;
      sb.delete();
      for (int k = 0; k < N_CH; k++) begin
        m_sh_cos[k] <= 31; m_sh_sin[k] <= 0;
        m_act_cos[k] <= 31; m_act_sin[k] <= 0;
      end
    end else begin
      if (in_valid) sb.push_back(predict(cyc));
      for (int k = 0; k < N_CH; k++) begin
        if (coef_valid && m_ready && int'(coef_ch) == k) begin
          m_sh_cos[k] <= int'(coef_cos);
          m_sh_sin[k] <= int'(coef_sin);
        end
        if (coef_commit) begin
          m_act_cos[k] <= (coef_valid && m_ready && int'(coef_ch) == k) ? int'(coef_cos) : m_sh_cos[k];
          m_act_sin[k] <= (coef_valid && m_ready && int'(coef_ch) == k) ? int'(coef_sin) : m_sh_sin[k];
        end
      end
      m_ready <= !coef_commit;
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_i = '0;
      last_q = '0;
    end else if (out_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stale_valid: OUT_VALID=1 with no sample outstanding, I=%0d Q=%0d", i_total, q_total);
      end else begin
        e = sb.pop_front();
        if (i_total !== e.i || q_total !== e.q || ovf !== e.ovf || (cyc - e.cyc) != 3) begin
          n_fail++;
          $display("FAIL scoreboard: got I=%0d Q=%0d OVF=%0b lat=%0d, expected I=%0d Q=%0d OVF=%0b lat=3",
                   i_total, q_total, ovf, cyc - e.cyc, e.i, e.q, e.ovf);
        end
      end
      last_i = i_total;
      last_q = q_total;
    end else begin
      n_checks++;
      if (i_total !== last_i || q_total !== last_q) begin
        n_fail++;
        $display("FAIL hold: got I=%0d Q=%0d, expected held I=%0d Q=%0d", i_total, q_total, last_i, last_q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic write_coef(input int ch, input int c, input int s);
    int n = 0;
    while (coef_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (coef_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL coef_ready_timeout: got %0b, expected 1", coef_ready);
    end
    coef_valid = 1'b1;
    coef_ch = CH_W'(ch);
    coef_cos = COEF_W'(c);
    coef_sin = COEF_W'(s);
    tick();
    coef_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if (i_total !== 0 || q_total !== 0 || out_valid !== 0 || ovf !== 0 || coef_ready !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: got I=%0d Q=%0d V=%0b OVF=%0b RDY=%0b, expected all 0",
               i_total, q_total, out_valid, ovf, coef_ready);
    end
    rst = 1'b0;
    n_checks++;
    if (coef_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %0b, expected 0", coef_ready);
    end
    tick();
    n_checks++;
    if (coef_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %0b, expected 1", coef_ready);
    end
  endtask

  task automatic test_default();
    mask = 4'b1111; mode = 1'b0; adc = 4'b1111; in_valid = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      n_checks++;
      if (out_valid !== (t == 3)) begin
        n_fail++;
        $display("FAIL first_latency: tick %0d got OUT_VALID=%0b, expected %0b", t, out_valid, t == 3);
      end
    end
    n_checks++;
    if (i_total !== 8'sd124 || q_total !== 0 || ovf !== 0) begin
      n_fail++;
      $display("FAIL default_pos: got I=%0d Q=%0d OVF=%0b, expected 124 0 0", i_total, q_total, ovf);
    end
    tick(); tick();
    adc = 4'b0000;
    repeat (3) tick();
    drain();
    n_checks++;
    if (i_total !== -8'sd124 || q_total !== 0) begin
      n_fail++;
      $display("FAIL default_neg: got I=%0d Q=%0d, expected -124 0", i_total, q_total);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < N_CH; k++) write_coef(k, -32, -32);
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    n_checks++;
    if (coef_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_commit: got %0b, expected 0", coef_ready);
    end
    adc = 4'b0000; in_valid = 1'b1;
    repeat (3) tick();
    drain();
    n_checks++;
    if (i_total !== 8'sd127 || q_total !== 8'sd127 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos: got I=%0d Q=%0d OVF=%0b, expected 127 127 1", i_total, q_total, ovf);
    end
    adc = 4'b1111; in_valid = 1'b1;
    repeat (2) tick();
    drain();
    n_checks++;
    if (i_total !== -8'sd128 || q_total !== -8'sd128 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_min: got I=%0d Q=%0d OVF=%0b, expected -128 -128 0", i_total, q_total, ovf);
    end
  endtask

  task automatic test_shadow_commit();
    do_reset();
    mask = 4'b1111; mode = 1'b0; adc = 4'b1111; in_valid = 1'b1;
    repeat (3) tick();
    write_coef(2, 10, -5);
    repeat (3) tick();
    n_checks++;
    if (i_total !== 8'sd124) begin
      n_fail++;
      $display("FAIL shadow_isolated: got I=%0d, expected 124", i_total);
    end
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    for (int t = 0; t < 4; t++) begin
      n_checks++;
      if (i_total !== ((t < 3) ? 8'sd124 : 8'sd103) || q_total !== ((t < 3) ? 8'sd0 : -8'sd5)) begin
        n_fail++;
        $display("FAIL commit_boundary: tick %0d got I=%0d Q=%0d, expected %0d %0d",
                 t, i_total, q_total, (t < 3) ? 124 : 103, (t < 3) ? 0 : -5);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_mask_monitor();
    mask = 4'b0001; adc = 4'b1111; in_valid = 1'b1;
    repeat (3) tick();
    drain();
    n_checks++;
    if (i_total !== 8'sd31 || q_total !== 0) begin
      n_fail++;
      $display("FAIL mask_one: got I=%0d Q=%0d, expected 31 0", i_total, q_total);
    end
    mode = 1'b1; mon_ch = 2'd3; adc = 4'b0111; in_valid = 1'b1;
    repeat (3) tick();
    drain();
    n_checks++;
    if (i_total !== -8'sd31 || q_total !== 0) begin
      n_fail++;
      $display("FAIL monitor: got I=%0d Q=%0d, expected -31 0", i_total, q_total);
    end
    mode = 1'b0; mask = 4'b1111;
  endtask

  task automatic test_valid_gap();
    logic [3:0] vpat = 4'b0101;
    in_valid = 1'b1; adc = 4'b1111; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; adc = 4'b0000; tick();
    in_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      n_checks++;
      if (out_valid !== vpat[t] || i_total !== ((t < 2) ? 8'sd103 : -8'sd103)) begin
        n_fail++;
        $display("FAIL valid_gap: step %0d got V=%0b I=%0d, expected V=%0b I=%0d",
                 t, out_valid, i_total, vpat[t], (t < 2) ? 103 : -103);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    adc = 4'b1111; in_valid = 1'b1;
    repeat (2) tick();
    write_coef(1, -32, 7);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 0 || i_total !== 0 || q_total !== 0 || ovf !== 0 || coef_ready !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got V=%0b I=%0d Q=%0d OVF=%0b RDY=%0b, expected all 0",
               out_valid, i_total, q_total, ovf, coef_ready);
    end
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      n_checks++;
      if (out_valid !== (t == 3)) begin
        n_fail++;
        $display("FAIL post_reset_valid: tick %0d got %0b, expected %0b", t, out_valid, t == 3);
      end
    end
    drain();
    coef_commit = 1'b1; tick(); coef_commit = 1'b0;
    in_valid = 1'b1; repeat (2) tick();
    drain();
    n_checks++;
    if (i_total !== 8'sd124 || q_total !== 0) begin
      n_fail++;
      $display("FAIL shadow_lost: got I=%0d Q=%0d, expected 124 0", i_total, q_total);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_saturate();
    test_shadow_commit();
    test_mask_monitor();
    test_valid_gap();
    test_reset_midstream();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
